mjpeg_word_packer: RTL and testbench
====================================

Name: mjpeg_word_packer

Overview:
- Sits directly downstream of the MJPEG encoder and upstream of the DDR3 write master, in the encoder clock domain.
- Collects the encoder's byte stream (data / valid / done) into 128-bit little-endian words with byte masks.
- Marks the last word of each frame and reports per-frame byte length and frame rank for the UDP header path.
- Provides a 2-entry output buffer, because the encoder cannot be back-pressured.

Parameters:
- WORD_BYTES, 16, bytes per output word; output word width is 8*WORD_BYTES.
- LEN_W, 24, width of the frame byte-length counter.
- RANK_W, 15, width of the frame rank counter; matches the UDP frame-rank field.
- FIFO_DEPTH, 2, output buffer entries; power of two.

Ports:
- clk  in  1  encoder clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  packer enable. A frame is only accepted when it starts while i_en=1.
- i_mjpeg_de  in  1  encoder byte valid.
- i_mjpeg_data  in  8  encoder byte.
- i_mjpeg_down  in  1  encoder frame-done level. A rising edge ends the frame.
- o_word_valid  out  1  output word available.
- i_word_ready  in  1  consumer accepts the word when valid & ready.
- o_word_data  out  8*WORD_BYTES  packed word; byte k at bits [8k+7:8k]; first byte of the frame at k=0.
- o_word_mask  out  WORD_BYTES  DDR3 write mask; 1 = byte invalid (padding).
- o_word_last  out  1  last word of the frame.
- o_frame_done  out  1  one-cycle pulse when the last word enters the buffer.
- o_frame_len  out  LEN_W  byte count of the finished frame; held until the next frame_done.
- o_frame_rank  out  RANK_W  rank of the finished frame; held until the next frame_done.
- o_overflow  out  1  sticky: a word was dropped because the buffer was full.
- i_clr_overflow  in  1  clears o_overflow.

Behaviour:
- Reset values: all outputs 0; internal byte index 0; length 0; rank counter 0; FIFO empty; FSM in IDLE.
- Reset is asynchronous and may occur mid-frame. The partial word is discarded, no frame_done is produced, and the rank counter returns to 0.
- Done edge detect: done_rise = i_mjpeg_down & ~down_q, where down_q is registered every cycle.
- FSM states:
  - IDLE:
    - Go to FILL on (i_en & i_mjpeg_de).
    - Go to FLUSH on (i_en & done_rise) when no byte is present; this is a zero-length frame.
    - Bytes while i_en=0 are ignored.
  - FILL:
    - Each valid byte is written to lane idx, idx increments, and len increments, saturating at 2^LEN_W-1.
    - When idx wraps from WORD_BYTES-1 to 0, the full word (mask all 0, last=0) is pushed.
    - On done_rise, go to FLUSH. A byte valid in the same cycle as done_rise belongs to this frame and is packed first.
  - FLUSH (1 cycle):
    - If idx!=0: push the partial word with last=1. Mask bits [idx..WORD_BYTES-1] = 1, and those data lanes are 0.
    - If idx==0 and at least one full word was pushed this frame: the previously pushed word cannot be re-marked, so push an all-masked word (mask all 1) with last=1.
    - If the frame has zero bytes: push nothing.
    - In every case, pulse o_frame_done, latch len and rank, increment rank (wraps), clear idx and len, and go to IDLE.
    - Bytes arriving during FLUSH are dropped, and the overflow flag is set.
- Latency: the word completed by a byte at cycle n appears on o_word_valid at n+1 if the FIFO was empty. The FLUSH word appears at n+2 after done_rise at cycle n.
- FIFO:
  - Push and pop in the same cycle are allowed when full.
  - A push while full and not popping drops the word and sets o_overflow. If that word carried last, frame_done still pulses.
  - Outputs are driven from the FIFO head register; o_word_data is stable while valid & ~ready.
- Overflow flag: i_clr_overflow has priority over a new set in the same cycle.
- Rank wraps from 2^RANK_W-1 to 0.

Decomposition:
- Shared package mjpeg_pack_pkg holds:
  - typedef pack_state_e {IDLE, FILL, FLUSH};
  - typedef packed struct pack_word_t {data, mask, last};
  - localparam defaults for WORD_BYTES, LEN_W and RANK_W.
- One sub-module, pack_word_fifo: synchronous FIFO of pack_word_t with FIFO_DEPTH entries, full/empty flags and async active-low reset.

Test Plan:
- 32 bytes 0x00..0x1F, ready=1, then done edge:
  - word0 = bytes 0x0F..0x00 (byte k = 0x0k), mask 0x0000, last=0.
  - word1 = bytes 0x1F..0x10, mask 0x0000, last=0.
  - word2 mask 0xFFFF, last=1.
  - len=32, rank=0.
- 5 bytes 0xA0..0xA4, with done rising in the same cycle as byte 0xA4:
  - one word, lanes0-4 = A0..A4, mask 0xFFE0, last=1.
  - len=5; rank=1 if this follows the previous test.
- Done edge with no bytes and i_en=1: no word, o_frame_done pulses, len=0.
- ready held 0 for 48 bytes:
  - first two words buffered, third dropped, o_overflow=1.
  - After ready rises, exactly 2 words pop in order.
  - i_clr_overflow clears the flag.
- rst_n asserted after 7 bytes: all outputs 0 immediately (asynchronous); the next 16-byte frame yields word lanes = new bytes and rank=0.
- 2^RANK_W frames of 1 byte each: o_frame_rank wraps from 32767 to 0.

Source files
------------

// File: rtl/mjpeg_pack_pkg.sv
// Shared types and defaults for the MJPEG byte-to-word packer.
package mjpeg_pack_pkg;

  localparam int DEF_WORD_BYTES = 16;
  localparam int DEF_LEN_W      = 24;
  localparam int DEF_RANK_W     = 15;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } pack_state_e;

  typedef struct packed {
    logic [8*DEF_WORD_BYTES-1:0] data;
    logic [DEF_WORD_BYTES-1:0]   mask;
    logic                        last;
  } pack_word_t;

  // Write mask for a partial word holding idx valid bytes: lanes idx.. are padding.
  function automatic logic [DEF_WORD_BYTES-1:0] partial_mask(input int unsigned idx);
    for (int k = 0; k < DEF_WORD_BYTES; k++) begin
      partial_mask[k] = (32'(k) >= idx);
    end
  endfunction

endpackage

// File: rtl/pack_word_fifo.sv
// Small synchronous FIFO of packed words; the head entry drives the outputs directly.
module pack_word_fifo
  import mjpeg_pack_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  pack_word_t i_word,
  input  logic       i_pop,
  output pack_word_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  pack_word_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, because the head entry is a module output
      // and must read as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so pointer and count updates never see each other's new value.
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mjpeg_word_packer.sv
// Packs the encoder byte stream into little-endian words with DDR3 write masks,
// marks frame ends and reports frame length and rank.
module mjpeg_word_packer
  import mjpeg_pack_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int RANK_W     = DEF_RANK_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_mjpeg_de,
  input  logic [7:0]              i_mjpeg_data,
  input  logic                    i_mjpeg_down,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic [8*WORD_BYTES-1:0] o_word_data,
  output logic [WORD_BYTES-1:0]   o_word_mask,
  output logic                    o_word_last,
  output logic                    o_frame_done,
  output logic [LEN_W-1:0]        o_frame_len,
  output logic [RANK_W-1:0]       o_frame_rank,
  output logic                    o_overflow,
  input  logic                    i_clr_overflow
);

  localparam int               IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  pack_state_e                   r_state;
  pack_state_e                   w_state_nxt;
  logic                          r_down_q;
  logic [WORD_BYTES-1:0][7:0]    r_lanes;
  logic [WORD_BYTES-1:0][7:0]    w_lanes_merged;
  logic [IDX_W-1:0]              r_idx;
  logic [LEN_W-1:0]              r_len;
  logic                          r_word_seen;
  logic [RANK_W-1:0]             r_rank;
  logic                          r_frame_done;
  logic [LEN_W-1:0]              r_frame_len;
  logic [RANK_W-1:0]             r_frame_rank;
  logic                          r_overflow;

  logic                          w_done_rise;
  logic                          w_take_byte;
  logic                          w_flush;
  logic                          w_byte_in_flush;
  logic                          w_word_full;
  logic                          w_push;
  logic                          w_fifo_drop;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  pack_word_t                    w_push_word;
  pack_word_t                    w_head;

  assign w_done_rise = i_mjpeg_down & ~r_down_q;
  assign w_word_full = w_take_byte && (r_idx == IDX_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_take_byte     = 1'b0;
    w_flush         = 1'b0;
    w_byte_in_flush = 1'b0;
    case (r_state)
      IDLE: begin
        // A byte and the done edge together form a frame that is flushed at once.
        if (i_en && i_mjpeg_de) begin
          w_take_byte = 1'b1;
          w_state_nxt = w_done_rise ? FLUSH : FILL;
        end else if (i_en && w_done_rise) begin
          w_state_nxt = FLUSH;
        end
      end
      FILL: begin
        w_take_byte = i_mjpeg_de;
        if (w_done_rise) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_flush         = 1'b1;
        w_byte_in_flush = i_mjpeg_de;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_lanes_merged        = r_lanes;
    w_lanes_merged[r_idx] = i_mjpeg_data;
  end

  // Lanes above idx are always zero, so the partial word needs no extra blanking.
  always_comb begin
    w_push      = 1'b0;
    w_push_word = '0;
    if (w_word_full) begin
      w_push           = 1'b1;
      w_push_word.data = w_lanes_merged;
    end else if (w_flush && (r_idx != '0)) begin
      w_push           = 1'b1;
      w_push_word.data = r_lanes;
      w_push_word.mask = partial_mask(32'(r_idx));
      w_push_word.last = 1'b1;
    end else if (w_flush && r_word_seen) begin
      w_push           = 1'b1;
      w_push_word.mask = '1;
      w_push_word.last = 1'b1;
    end
  end

  assign w_fifo_drop = w_push & w_fifo_full & ~i_word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_down_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_down_q <= i_mjpeg_down;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lanes     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_word_seen <= 1'b0;
      r_rank      <= '0;
    end else if (w_flush) begin
      r_lanes     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_word_seen <= 1'b0;
      r_rank      <= r_rank + 1'b1;
    end else if (w_take_byte) begin
      r_lanes <= w_word_full ? '0 : w_lanes_merged;
      r_idx   <= w_word_full ? '0 : r_idx + 1'b1;
      if (r_len != '1) begin
        r_len <= r_len + 1'b1;
      end
      if (w_word_full) begin
        r_word_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_frame_len  <= '0;
      r_frame_rank <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_flush;
      if (w_flush) begin
        r_frame_len  <= r_len;
        r_frame_rank <= r_rank;
      end
      if (i_clr_overflow) begin
        r_overflow <= 1'b0;
      end else if (w_fifo_drop || w_byte_in_flush) begin
        r_overflow <= 1'b1;
      end
    end
  end

  pack_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_word  (w_push_word),
    .i_pop   (i_word_ready),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_word_valid = ~w_fifo_empty;
  assign o_word_data  = w_head.data;
  assign o_word_mask  = w_head.mask;
  assign o_word_last  = w_head.last;
  assign o_frame_done = r_frame_done;
  assign o_frame_len  = r_frame_len;
  assign o_frame_rank = r_frame_rank;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_mjpeg_word_packer.sv
// Scoreboard bench for mjpeg_word_packer: words and frame reports are predicted
// from the driven byte stream and compared as the DUT produces them.
module tb_mjpeg_word_packer;
  import mjpeg_pack_pkg::*;

  localparam int WB     = DEF_WORD_BYTES;
  localparam int LEN_W  = DEF_LEN_W;
  localparam int RANK_W = DEF_RANK_W;
  localparam int IDX_W  = $clog2(WB);

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [RANK_W-1:0] rank;
  } frame_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                i_en = 1'b0;
  logic                i_mjpeg_de = 1'b0;
  logic [7:0]          i_mjpeg_data = 8'h00;
  logic                i_mjpeg_down = 1'b0;
  logic                i_word_ready = 1'b0;
  logic                i_clr_overflow = 1'b0;
  logic                o_word_valid;
  logic [8*WB-1:0]     o_word_data;
  logic [WB-1:0]       o_word_mask;
  logic                o_word_last;
  logic                o_frame_done;
  logic [LEN_W-1:0]    o_frame_len;
  logic [RANK_W-1:0]   o_frame_rank;
  logic                o_overflow;

  int checks = 0;
  int errors = 0;

  pack_word_t exp_q [$];
  frame_t     exp_fd_q [$];

  logic [WB-1:0][7:0]  m_lanes;
  logic [IDX_W-1:0]    m_idx;
  logic                m_seen;
  logic [LEN_W-1:0]    m_len;
  logic [RANK_W-1:0]   m_rank;
  bit                  m_drop;

  mjpeg_word_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (i_en),
    .i_mjpeg_de     (i_mjpeg_de),
    .i_mjpeg_data   (i_mjpeg_data),
    .i_mjpeg_down   (i_mjpeg_down),
    .o_word_valid   (o_word_valid),
    .i_word_ready   (i_word_ready),
    .o_word_data    (o_word_data),
    .o_word_mask    (o_word_mask),
    .o_word_last    (o_word_last),
    .o_frame_done   (o_frame_done),
    .o_frame_len    (o_frame_len),
    .o_frame_rank   (o_frame_rank),
    .o_overflow     (o_overflow),
    .i_clr_overflow (i_clr_overflow)
  );

  always #5 clk = ~clk;

  // Consumer side: compare every accepted word and every frame report.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_word_valid && i_word_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected data=%h mask=%h last=%b required=no word",
                   o_word_data, o_word_mask, o_word_last);
        end else begin
          pack_word_t w;
          w = exp_q.pop_front();
          if ({o_word_data, o_word_mask, o_word_last} !== w) begin
            errors++;
            $display("FAIL word data=%h mask=%h last=%b required data=%h mask=%h last=%b",
                     o_word_data, o_word_mask, o_word_last, w.data, w.mask, w.last);
          end
        end
      end
      if (o_frame_done) begin
        checks++;
        if (exp_fd_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected len=%0d rank=%0d required=no frame_done",
                   o_frame_len, o_frame_rank);
        end else begin
          frame_t f;
          f = exp_fd_q.pop_front();
          if (o_frame_len !== f.len || o_frame_rank !== f.rank) begin
            errors++;
            $display("FAIL frame_info len=%0d rank=%0d required len=%0d rank=%0d",
                     o_frame_len, o_frame_rank, f.len, f.rank);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lanes = '0;
    m_idx   = '0;
    m_seen  = 1'b0;
    m_len   = '0;
  endtask

  task automatic model_push(input logic [8*WB-1:0] d, input logic [WB-1:0] mk, input logic l);
    pack_word_t w;
    w.data = d;
    w.mask = mk;
    w.last = l;
    if (!m_drop) exp_q.push_back(w);
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_lanes[m_idx] = b;
    if (m_len != '1) m_len = m_len + 1'b1;
    if (int'(m_idx) == WB - 1) begin
      model_push(m_lanes, '0, 1'b0);
      m_seen  = 1'b1;
      m_lanes = '0;
      m_idx   = '0;
    end else begin
      m_idx = m_idx + 1'b1;
    end
  endtask

  task automatic model_flush();
    logic [WB-1:0] mk;
    frame_t        f;
    if (m_idx != '0) begin
      for (int k = 0; k < WB; k++) mk[k] = (k >= int'(m_idx));
      model_push(m_lanes, mk, 1'b1);
    end else if (m_seen) begin
      model_push('0, '1, 1'b1);
    end
    f.len  = m_len;
    f.rank = m_rank;
    exp_fd_q.push_back(f);
    m_rank = m_rank + 1'b1;
    model_reset();
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic with_done);
    i_mjpeg_de   = 1'b1;
    i_mjpeg_data = b;
    i_mjpeg_down = with_done;
    model_byte(b);
    if (with_done) model_flush();
    tick();
    i_mjpeg_de   = 1'b0;
    i_mjpeg_down = 1'b0;
  endtask

  task automatic drive_done();
    i_mjpeg_down = 1'b1;
    model_flush();
    tick();
    i_mjpeg_down = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || exp_fd_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp_fd_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain words_left=%0d frames_left=%0d required 0 and 0",
               tag, exp_q.size(), exp_fd_q.size());
      exp_q.delete();
      exp_fd_q.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_word_valid, o_word_data, o_word_mask, o_word_last} !== '0) begin
      errors++;
      $display("FAIL reset_word valid=%b data=%h mask=%h last=%b required all 0",
               o_word_valid, o_word_data, o_word_mask, o_word_last);
    end
    checks++;
    if ({o_frame_done, o_frame_len, o_frame_rank, o_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_frame done=%b len=%0d rank=%0d ovf=%b required all 0",
               o_frame_done, o_frame_len, o_frame_rank, o_overflow);
    end
    tick();
    tick();
    rst_n = 1'b1;
    m_rank = '0;
    m_drop = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_full_words();
    logic [8*WB-1:0] e;
    i_en = 1'b1;
    i_word_ready = 1'b1;
    for (int k = 0; k < WB; k++) e[8*k +: 8] = 8'(k);
    for (int i = 0; i < 32; i++) begin
      drive_byte(8'(i), 1'b0);
      if (i == 15) begin
        checks++;
        if (o_word_valid !== 1'b1 || o_word_data !== e) begin
          errors++;
          $display("FAIL full_latency valid=%b data=%h required valid=1 data=%h",
                   o_word_valid, o_word_data, e);
        end
      end
    end
    drive_done();
    tick();
    checks++;
    if (o_frame_done !== 1'b1 || o_frame_len !== 24'd32 || o_frame_rank !== 15'd0) begin
      errors++;
      $display("FAIL full_frame done=%b len=%0d rank=%0d required done=1 len=32 rank=0",
               o_frame_done, o_frame_len, o_frame_rank);
    end
    wait_drain(10, "full");
  endtask

  task automatic test_partial();
    for (int i = 0; i < 5; i++) drive_byte(8'hA0 + 8'(i), (i == 4));
    tick();
    checks++;
    if (o_word_valid !== 1'b1 || o_word_data[39:0] !== 40'hA4A3A2A1A0 ||
        o_word_mask !== 16'hFFE0 || o_word_last !== 1'b1) begin
      errors++;
      $display("FAIL partial_word valid=%b lanes=%h mask=%h last=%b required 1 a4a3a2a1a0 ffe0 1",
               o_word_valid, o_word_data[39:0], o_word_mask, o_word_last);
    end
    checks++;
    if (o_frame_done !== 1'b1 || o_frame_len !== 24'd5 || o_frame_rank !== 15'd1) begin
      errors++;
      $display("FAIL partial_frame done=%b len=%0d rank=%0d required 1 5 1",
               o_frame_done, o_frame_len, o_frame_rank);
    end
    wait_drain(10, "partial");
  endtask

  task automatic test_zero_length();
    drive_done();
    tick();
    checks++;
    if (o_frame_done !== 1'b1 || o_frame_len !== 24'd0 || o_word_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_frame done=%b len=%0d valid=%b required 1 0 0",
               o_frame_done, o_frame_len, o_word_valid);
    end
    tick();
    checks++;
    if (o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_width done=%b required 0", o_frame_done);
    end
    wait_drain(10, "zero");
  endtask

  task automatic test_en_gating();
    i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_mjpeg_de = 1'b1;
      i_mjpeg_data = 8'h30 + 8'(i);
      tick();
    end
    i_mjpeg_de = 1'b0;
    i_mjpeg_down = 1'b1;
    tick();
    i_mjpeg_down = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (o_word_valid !== 1'b0 || o_frame_len !== 24'd0 || o_frame_rank !== 15'd2) begin
      errors++;
      $display("FAIL en_gating valid=%b len=%0d rank=%0d required 0 0 2",
               o_word_valid, o_frame_len, o_frame_rank);
    end
    i_en = 1'b1;
  endtask

  task automatic test_overflow();
    i_word_ready = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 32) begin
        checks++;
        if (o_overflow !== 1'b0 || o_word_valid !== 1'b1) begin
          errors++;
          $display("FAIL ovf_before ovf=%b valid=%b required 0 1", o_overflow, o_word_valid);
        end
        m_drop = 1'b1;
      end
      drive_byte(8'(i * 7 + 3), 1'b0);
    end
    checks++;
    if (o_overflow !== 1'b1 || o_word_data !== exp_q[0].data) begin
      errors++;
      $display("FAIL ovf_set ovf=%b head=%h required ovf=1 head=%h",
               o_overflow, o_word_data, exp_q[0].data);
    end
    drive_done();
    tick();
    checks++;
    if (o_frame_done !== 1'b1 || o_frame_len !== 24'd48 || o_frame_rank !== 15'd3) begin
      errors++;
      $display("FAIL ovf_frame done=%b len=%0d rank=%0d required 1 48 3",
               o_frame_done, o_frame_len, o_frame_rank);
    end
    m_drop = 1'b0;
    i_word_ready = 1'b1;
    wait_drain(10, "ovf");
    tick();
    checks++;
    if (o_word_valid !== 1'b0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pop valid=%b ovf=%b required 0 1", o_word_valid, o_overflow);
    end
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b required 0", o_overflow);
    end
  endtask

  task automatic test_back_to_back();
    i_word_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 47) i_word_ready = 1'b1;
      drive_byte(8'($urandom), 1'b0);
    end
    drive_done();
    wait_drain(20, "b2b");
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_push_pop_full ovf=%b required 0", o_overflow);
    end
  endtask

  task automatic test_flush_byte();
    drive_byte(8'h55, 1'b1);
    i_mjpeg_de = 1'b1;
    i_mjpeg_data = 8'hEE;
    i_clr_overflow = 1'b1;
    tick();
    i_mjpeg_de = 1'b0;
    i_clr_overflow = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority ovf=%b required 0", o_overflow);
    end
    wait_drain(10, "flush1");
    drive_byte(8'h66, 1'b1);
    i_mjpeg_de = 1'b1;
    i_mjpeg_data = 8'hEE;
    tick();
    i_mjpeg_de = 1'b0;
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_byte_drop ovf=%b required 1", o_overflow);
    end
    wait_drain(10, "flush2");
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [8*WB-1:0] e;
    for (int i = 0; i < 7; i++) drive_byte(8'h70 + 8'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_word_valid, o_word_data, o_word_mask, o_word_last, o_frame_done,
         o_frame_len, o_frame_rank, o_overflow} !== '0) begin
      errors++;
      $display("FAIL async_reset valid=%b mask=%h done=%b len=%0d rank=%0d ovf=%b required all 0",
               o_word_valid, o_word_mask, o_frame_done, o_frame_len, o_frame_rank, o_overflow);
    end
    exp_q.delete();
    exp_fd_q.delete();
    model_reset();
    m_rank = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < WB; k++) e[8*k +: 8] = 8'hC0 + 8'(k);
    for (int i = 0; i < 16; i++) drive_byte(8'hC0 + 8'(i), 1'b0);
    checks++;
    if (o_word_valid !== 1'b1 || o_word_data !== e || o_word_mask !== 16'h0000) begin
      errors++;
      $display("FAIL reset_new_word valid=%b data=%h mask=%h required 1 %h 0000",
               o_word_valid, o_word_data, o_word_mask, e);
    end
    drive_done();
    tick();
    checks++;
    if (o_frame_rank !== 15'd0 || o_frame_len !== 24'd16) begin
      errors++;
      $display("FAIL reset_rank rank=%0d len=%0d required 0 16", o_frame_rank, o_frame_len);
    end
    wait_drain(10, "rstmid");
  endtask

  task automatic test_rank_wrap();
    // Rank counter is at 1 here; 32768 one-byte frames report 1..32767 then 0.
    for (int i = 0; i < 32768; i++) begin
      drive_byte(8'(i), 1'b1);
      tick();
      if (i == 32766) begin
        checks++;
        if (o_frame_rank !== 15'd32767) begin
          errors++;
          $display("FAIL rank_max rank=%0d required 32767", o_frame_rank);
        end
      end
      if (i == 32767) begin
        checks++;
        if (o_frame_rank !== 15'd0) begin
          errors++;
          $display("FAIL rank_wrap rank=%0d required 0", o_frame_rank);
        end
      end
    end
    wait_drain(10, "rank");
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_zero_length();
    test_en_gating();
    test_overflow();
    test_back_to_back();
    test_flush_byte();
    test_reset_mid_frame();
    test_rank_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog time=%0t required completion before 2000000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
